// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Holds the arbiter state encoding and the BCD converter sizing.
package sseg_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CONV, SHOW} state_t;

  localparam int MAX_DISPLAY = 9999;
  localparam int BCD_DIGITS  = 4;
  localparam int CONV_STEPS  = 14;

  // Shift-add-3 correction: any BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] b);
    logic [4*BCD_DIGITS-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [1:0] grant_of(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sseg_display_arbiter_bin2bcd_seq.sv
// Iterative 14-bit binary to 4-digit BCD converter, one shift-add-3 step per cycle.
// done and bcd are combinational for the final step so the caller can capture the result that edge.
module bin2bcd_seq
  import sseg_pkg::*;
(
  input  logic                    clock_100Mhz,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [CONV_STEPS-1:0]   bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  logic [CONV_STEPS-1:0]   shift_q;
  logic [4*BCD_DIGITS-1:0] acc_q;
  logic [4*BCD_DIGITS-1:0] acc_adj;
  logic [4*BCD_DIGITS-1:0] acc_next;
  logic [3:0]              step_q;
  logic                    active_q;

  always_comb begin
    acc_adj  = bcd_adjust(acc_q);
    acc_next = {acc_adj[4*BCD_DIGITS-2:0], shift_q[CONV_STEPS-1]};
    done     = active_q && (step_q == 4'(CONV_STEPS - 1));
    bcd      = acc_next;
  end

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      shift_q  <= bin;
      acc_q    <= '0;
      step_q   <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      shift_q  <= {shift_q[CONV_STEPS-2:0], 1'b0};
      acc_q    <= acc_next;
      step_q   <= step_q + 4'd1;
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum hold per grant;
// the granted value is clamped to 9999 and converted to BCD before it is shown.
module sseg_display_arbiter
  import sseg_pkg::*;
#(
  parameter int HOLD_CYCLES = 100000000,
  parameter int HOLD_W      = 27
) (
  input  logic        clock_100Mhz,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [15:0] value0,
  input  logic [15:0] value1,
  output logic [1:0]  grant,
  output logic [15:0] bcd_digits,
  output logic        digits_valid,
  output logic        overflow,
  output logic        busy,
  output state_t      dbg_state
);

  state_t                  state_q;
  logic [HOLD_W-1:0]       hold_q;
  logic                    rr_ptr;
  logic                    owner;
  logic                    other;
  logic                    idle_pick;
  logic                    hold_done;
  logic [15:0]             sel_value;
  logic                    clamp_over;
  logic [CONV_STEPS-1:0]   conv_in;
  logic                    conv_start;
  logic                    conv_done;
  logic [4*BCD_DIGITS-1:0] conv_bcd;

  always_comb begin
    owner      = grant[1];
    other      = ~grant[1];
    idle_pick  = (req == 2'b11) ? rr_ptr : req[1];
    hold_done  = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
    sel_value  = grant[1] ? value1 : value0;
    clamp_over = (sel_value > 16'(MAX_DISPLAY));
    conv_in    = clamp_over ? CONV_STEPS'(MAX_DISPLAY) : sel_value[CONV_STEPS-1:0];
    conv_start = (state_q == LOAD);
  end

  assign dbg_state = state_q;

  bin2bcd_seq u_bin2bcd (
    .clock_100Mhz (clock_100Mhz),
    .reset_n      (reset_n),
    .start        (conv_start),
    .bin          (conv_in),
    .done         (conv_done),
    .bcd          (conv_bcd)
  );

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      rr_ptr       <= 1'b0;
      grant        <= 2'b00;
      bcd_digits   <= '0;
      digits_valid <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant   <= grant_of(idle_pick);
            rr_ptr  <= ~idle_pick;
            busy    <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          overflow <= clamp_over;
          state_q  <= CONV;
        end
        CONV: begin
          if (conv_done) begin
            bcd_digits   <= conv_bcd;
            digits_valid <= 1'b1;
            busy         <= 1'b0;
            hold_q       <= '0;
            state_q      <= SHOW;
          end
        end
        SHOW: begin
          // A dropped owner request cuts the hold short.
          if (!req[owner] || hold_done) begin
            if (req[other]) begin
              grant        <= grant_of(other);
              rr_ptr       <= owner;
              digits_valid <= 1'b0;
              busy         <= 1'b1;
              state_q      <= LOAD;
            end else if (req[owner]) begin
              busy    <= 1'b1;
              state_q <= LOAD;
            end else begin
              grant        <= 2'b00;
              digits_valid <= 1'b0;
              state_q      <= IDLE;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench for sseg_display_arbiter with a per-cycle timeline model of grants and display.
module tb_sseg_display_arbiter;

  localparam int HOLD = 20;

  logic        clock_100Mhz;
  logic        reset_n;
  logic [1:0]  req;
  logic [15:0] value0;
  logic [15:0] value1;
  logic [1:0]  grant;
  logic [15:0] bcd_digits;
  logic        digits_valid;
  logic        overflow;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  sseg_display_arbiter #(.HOLD_CYCLES(HOLD), .HOLD_W(5)) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset_n      (reset_n),
    .req          (req),
    .value0       (value0),
    .value1       (value1),
    .grant        (grant),
    .bcd_digits   (bcd_digits),
    .digits_valid (digits_valid),
    .overflow     (overflow),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial begin
    clock_100Mhz = 1'b0;
    forever #5 clock_100Mhz = ~clock_100Mhz;
  end

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Timeline model: owner, age since the grant's LOAD cycle, decimal value shown.
  int m_owner = -1;
  int m_age   = 0;
  int m_ptr   = 0;
  int m_val   = 0;
  int m_ovf   = 0;
  int m_shown = 0;
  int m_valid = 0;
  int m_busy  = 0;

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic model_step();
    int hold;
    int oth;
    int raw;
    if (!reset_n) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_val = 0;
      m_ovf = 0; m_shown = 0; m_valid = 0; m_busy = 0;
    end else if (m_owner < 0) begin
      if (req != 2'b00) begin
        m_owner = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
        m_ptr   = 1 - m_owner;
        m_age   = 0;
        m_busy  = 1;
      end
    end else if (m_age == 0) begin
      raw   = (m_owner == 1) ? int'(value1) : int'(value0);
      m_ovf = (raw > 9999) ? 1 : 0;
      m_val = (raw > 9999) ? 9999 : raw;
      m_age = 1;
    end else if (m_age < 14) begin
      m_age++;
    end else if (m_age == 14) begin
      m_shown = m_val;
      m_valid = 1;
      m_busy  = 0;
      m_age   = 15;
    end else begin
      hold = m_age - 15;
      oth  = 1 - m_owner;
      if (!req[m_owner] || hold == HOLD - 1) begin
        if (req[oth]) begin
          m_owner = oth; m_ptr = 1 - oth; m_age = 0; m_valid = 0; m_busy = 1;
        end else if (req[m_owner]) begin
          m_age = 0; m_busy = 1;
        end else begin
          m_owner = -1; m_valid = 0;
        end
      end else begin
        m_age++;
      end
    end
  endtask

  // scoreboard: compare every cycle against the model
  initial begin
    forever begin
      @(posedge clock_100Mhz);
      model_step();
      #1;
      check("cyc_grant", 16'(grant), (m_owner < 0) ? 16'h0 : ((m_owner == 0) ? 16'h1 : 16'h2));
      check("cyc_bcd", bcd_digits, to_bcd(m_shown));
      check("cyc_valid", 16'(digits_valid), 16'(m_valid));
      check("cyc_ovf", 16'(overflow), 16'(m_ovf));
      check("cyc_busy", 16'(busy), 16'(m_busy));
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clock_100Mhz);
    reset_n = 1'b0;
    req     = 2'b00;
    @(posedge clock_100Mhz);
    @(posedge clock_100Mhz);
    @(negedge clock_100Mhz);
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (digits_valid !== 1'b1 && n < budget) begin
      @(posedge clock_100Mhz); #1; n++;
    end
    check(name, 16'(digits_valid), 16'h1);
  endtask

  task automatic wait_grant(input string name, input logic [1:0] g, input int budget, output int cycles);
    cycles = 0;
    while (grant !== g && cycles < budget) begin
      @(posedge clock_100Mhz); #1; cycles++;
    end
    check(name, 16'(grant), 16'(g));
  endtask

  task automatic wait_bcd(input string name, input logic [15:0] v, input int budget, output logic dropped);
    int n;
    n = 0;
    dropped = 1'b0;
    while (bcd_digits !== v && n < budget) begin
      @(posedge clock_100Mhz); #1; n++;
      if (digits_valid !== 1'b1) dropped = 1'b1;
    end
    check(name, bcd_digits, v);
  endtask

  // stimulus
  initial begin
    int   cyc;
    logic drop;
    reset_n = 1'b0;
    req     = 2'b00;
    value0  = 16'd0;
    value1  = 16'd0;
    repeat (2) @(posedge clock_100Mhz);
    #1;
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_bcd", bcd_digits, 16'h0);
    check("rst_valid", 16'(digits_valid), 16'h0);
    check("rst_ovf", 16'(overflow), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    @(negedge clock_100Mhz);
    reset_n = 1'b1;

    // single requester, latency
    @(negedge clock_100Mhz);
    req = 2'b01; value0 = 16'd1234;
    @(posedge clock_100Mhz); #1;
    check("t1_grant_n1", 16'(grant), 16'h1);
    check("t1_busy_load", 16'(busy), 16'h1);
    repeat (14) @(posedge clock_100Mhz);
    #1;
    check("t1_valid_n15", 16'(digits_valid), 16'h0);
    @(posedge clock_100Mhz); #1;
    check("t1_valid_n16", 16'(digits_valid), 16'h1);
    check("t1_bcd", bcd_digits, 16'h1234);
    check("t1_ovf", 16'(overflow), 16'h0);
    @(negedge clock_100Mhz);
    req = 2'b00;
    repeat (3) @(posedge clock_100Mhz);

    // simultaneous requests, round robin with hold
    do_reset();
    req = 2'b11; value0 = 16'd42; value1 = 16'd9000;
    wait_valid("t2_valid_a", 30);
    check("t2_grant_a", 16'(grant), 16'h1);
    check("t2_bcd_a", bcd_digits, 16'h0042);
    wait_grant("t2_grant_b", 2'b10, 40, cyc);
    check("t2_hold_len", 16'(cyc), 16'd20);
    wait_valid("t2_valid_b", 30);
    check("t2_bcd_b", bcd_digits, 16'h9000);
    wait_grant("t2_grant_back", 2'b01, 40, cyc);
    wait_valid("t2_valid_c", 30);
    check("t2_bcd_c", bcd_digits, 16'h0042);

    // overflow clamp, then same-owner refresh
    do_reset();
    req = 2'b10; value1 = 16'd12000;
    wait_valid("t3_valid", 30);
    check("t3_bcd_clamp", bcd_digits, 16'h9999);
    check("t3_ovf_set", 16'(overflow), 16'h1);
    @(negedge clock_100Mhz);
    value1 = 16'd7;
    wait_bcd("t3_bcd_refresh", 16'h0007, 60, drop);
    check("t3_valid_held", 16'(drop), 16'h0);
    check("t3_ovf_clear", 16'(overflow), 16'h0);

    // owner drops in SHOW with no other requester
    do_reset();
    req = 2'b01; value0 = 16'd321;
    wait_valid("t4_valid", 30);
    repeat (5) @(posedge clock_100Mhz);
    @(negedge clock_100Mhz);
    req = 2'b00;
    @(posedge clock_100Mhz); #1;
    check("t4_grant_idle", 16'(grant), 16'h0);
    check("t4_valid_idle", 16'(digits_valid), 16'h0);
    check("t4_bcd_kept", bcd_digits, 16'h0321);

    // reset mid-conversion
    @(negedge clock_100Mhz);
    req = 2'b01; value0 = 16'd5678;
    repeat (8) @(posedge clock_100Mhz);
    #1;
    check("t5_busy_conv", 16'(busy), 16'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_rst_grant", 16'(grant), 16'h0);
    check("t5_rst_bcd", bcd_digits, 16'h0);
    check("t5_rst_busy", 16'(busy), 16'h0);
    @(posedge clock_100Mhz);
    @(negedge clock_100Mhz);
    reset_n = 1'b1;
    wait_valid("t5_valid", 30);
    check("t5_bcd", bcd_digits, 16'h5678);

    // value change mid-conversion
    do_reset();
    req = 2'b01; value0 = 16'd555;
    repeat (4) @(posedge clock_100Mhz);
    @(negedge clock_100Mhz);
    value0 = 16'd777;
    wait_valid("t6_valid", 30);
    check("t6_bcd_old", bcd_digits, 16'h0555);
    wait_bcd("t6_bcd_new", 16'h0777, 60, drop);
    check("t6_valid_held", 16'(drop), 16'h0);

    @(negedge clock_100Mhz);
    req = 2'b00;
    repeat (3) @(posedge clock_100Mhz);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
